// File: rtl/comparator.sv
// comparator: registered MSB-first unsigned magnitude compare with optional saturating result counters.
// Counters are enabled by defining COMPARATOR_STATS_EN; otherwise they read 0 and stats_clr is ignored.
module comparator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             stats_clr,
  output logic             gt,
  output logic             eg,
  output logic             ut,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);
  logic gt_d, eg_d, ut_d, gt_q, eg_q, ut_q;
  // the first differing bit from the top decides; later bits are ignored
  always_comb begin
    gt_d = 1'b0;
    ut_d = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!gt_d && !ut_d) begin
        gt_d = a[i] & ~b[i];
        ut_d = ~a[i] & b[i];
      end
    end
    eg_d = ~(gt_d | ut_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_q <= 1'b0;
      eg_q <= 1'b0;
      ut_q <= 1'b0;
    end else begin
      gt_q <= gt_d;
      eg_q <= eg_d;
      ut_q <= ut_d;
    end
  end
  assign gt = gt_q;
  assign eg = eg_q;
  assign ut = ut_q;
`ifdef COMPARATOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] gt_cnt_d, eq_cnt_d, lt_cnt_d, gt_cnt_q, eq_cnt_q, lt_cnt_q;
  always_comb begin
    gt_cnt_d = stats_clr ? '0 : gt_cnt_q + CNT_W'(gt_d && gt_cnt_q != CNT_MAX);
    eq_cnt_d = stats_clr ? '0 : eq_cnt_q + CNT_W'(eg_d && eq_cnt_q != CNT_MAX);
    lt_cnt_d = stats_clr ? '0 : lt_cnt_q + CNT_W'(ut_d && lt_cnt_q != CNT_MAX);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt_cnt_q <= '0;
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
    end else begin
      gt_cnt_q <= gt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
    end
  end
  assign gt_cnt = gt_cnt_q;
  assign eq_cnt = eq_cnt_q;
  assign lt_cnt = lt_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign gt_cnt = '0;
  assign eq_cnt = '0;
  assign lt_cnt = '0;
`endif
endmodule

// File: tb/tb_comparator.sv
// tb_comparator: directed checks of the comparator flags, counters, saturation and async reset.
module tb_comparator;
`ifdef COMPARATOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] a = '0, b = '0;
  logic stats_clr = 1'b0;
  logic gt, eg, ut;
  logic [15:0] gt_cnt, eq_cnt, lt_cnt;
  int checks = 0, failures = 0;

  comparator #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .stats_clr(stats_clr),
    .gt(gt), .eg(eg), .ut(ut),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sx(input logic [15:0] v);
    return STATS ? v : 16'd0;
  endfunction

  typedef struct { logic [3:0] a; logic [3:0] b; logic [2:0] f; } vec_t;
  vec_t vecs [6] = '{
    '{4'd0,  4'd0,  3'b010}, '{4'd0,  4'd15, 3'b001},
    '{4'd15, 4'd0,  3'b100}, '{4'd15, 4'd15, 3'b010},
    '{4'd8,  4'd7,  3'b100}, '{4'd7,  4'd8,  3'b001}
  };

  initial begin
    repeat (4) begin
      @(negedge clk);
      a = 4'($urandom);
      b = 4'($urandom);
      #2;
      chk("rst_flags", {gt, eg, ut}, 3'b000);
      chk("rst_cnts", gt_cnt | eq_cnt | lt_cnt, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        a = 4'(i);
        b = 4'(j);
        @(negedge clk);
        chk($sformatf("sweep_%0d_%0d", i, j), {gt, eg, ut},
            i > j ? 3'b100 : i == j ? 3'b010 : 3'b001);
      end
    chk("sweep_gt_cnt", gt_cnt, sx(16'd120));
    chk("sweep_eq_cnt", eq_cnt, sx(16'd16));
    chk("sweep_lt_cnt", lt_cnt, sx(16'd120));
    foreach (vecs[k]) begin
      a = vecs[k].a;
      b = vecs[k].b;
      @(negedge clk);
      chk($sformatf("bound_%0d_%0d", vecs[k].a, vecs[k].b), {gt, eg, ut}, vecs[k].f);
    end
    a = 4'd3;
    b = 4'd2;
    @(negedge clk);
    #2;
    a = 4'd1;
    b = 4'd9;
    #1;
    chk("hold_between_edges", {gt, eg, ut}, 3'b100);
    @(negedge clk);
    chk("after_edge", {gt, eg, ut}, 3'b001);
    a = 4'd5;
    b = 4'd5;
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("clr_eq_cnt", eq_cnt, 0);
    chk("clr_gt_cnt", gt_cnt, 0);
    chk("clr_lt_cnt", lt_cnt, 0);
    @(negedge clk);
    chk("post_clr_eq_cnt", eq_cnt, sx(16'd1));
    a = 4'd15;
    b = 4'd14;
    repeat (70000) @(negedge clk);
    chk("sat_gt_cnt", gt_cnt, sx(16'hffff));
    repeat (5) @(negedge clk);
    chk("sat_hold_gt_cnt", gt_cnt, sx(16'hffff));
    chk("sat_eq_cnt", eq_cnt, sx(16'd1));
    chk("sat_lt_cnt", lt_cnt, 0);
    a = 4'd9;
    b = 4'd3;
    @(negedge clk);
    chk("pre_async_gt", {gt, eg, ut}, 3'b100);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_flags", {gt, eg, ut}, 3'b000);
    chk("async_cnts", gt_cnt | eq_cnt | lt_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    a = 4'd2;
    b = 4'd7;
    @(negedge clk);
    chk("first_after_rst", {gt, eg, ut}, 3'b001);
    chk("first_lt_cnt", lt_cnt, sx(16'd1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port a, input, WIDTH bits: operand A, unsigned.
REQ-006 Port b, input, WIDTH bits: operand B, unsigned.
REQ-007 Port gt, output, 1 bit: registered flag, high when A > B.
REQ-008 Port eg, output, 1 bit: registered flag, high when A == B.
REQ-009 Port ut, output, 1 bit: registered flag, high when A < B.
REQ-010 Port stats_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-011 Ports gt_cnt, eq_cnt and lt_cnt, output, CNT_W bits each: statistics counters.

Function
REQ-012 The comparison SHALL be unsigned magnitude over all WIDTH bits.
REQ-013 The comparison SHALL be built as an MSB-first cascade: the first differing bit decides the result; if no bit differs, the operands are equal.
REQ-014 gt, eg and ut SHALL be registered, with 1-cycle latency: operands sampled on edge N appear on the outputs after edge N.
REQ-015 Exactly one of gt, eg and ut SHALL be high in every cycle after the first post-reset edge (one-hot invariant).
REQ-016 The block SHALL compare every clock; there is no handshake and no hold state.
REQ-017 The boundary pairs (0,0), (0,max), (max,0) and (max,max) SHALL produce (eg), (ut), (gt) and (eg) respectively.
REQ-018 When COMPARATOR_STATS_EN is defined, each counter SHALL increment by 1 on every edge where its matching result is registered (gt_cnt for gt, eq_cnt for eg, lt_cnt for ut).
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 stats_clr SHALL clear all three counters to 0 on the next edge and SHALL take priority over an increment in the same cycle.
REQ-021 Operand changes between edges SHALL have no effect until the next rising edge.

Reset
REQ-022 While rst is high, gt=0, eg=0, ut=0 and all counters SHALL be 0, immediately and independent of clk.
REQ-023 On release of rst, the first rising edge SHALL register the comparison of the current a and b.
REQ-024 Reset asserted mid-operation SHALL discard all pending results; the one-hot invariant is suspended only while reset is active.

Configuration
REQ-025 Macro COMPARATOR_STATS_EN defined: the statistics counters and stats_clr SHALL be functional.
REQ-026 Macro COMPARATOR_STATS_EN undefined: the counter logic SHALL be omitted, gt_cnt, eq_cnt and lt_cnt SHALL be tied to 0, and stats_clr SHALL be ignored; gt, eg and ut behaviour SHALL be unchanged.

Verification
REQ-027 Hold rst=1 and toggle a and b -> gt=eg=ut=0 and all counters 0.
REQ-028 Exhaustive sweep: a=0..15 outer loop, b=0..15 inner loop, one pair per clock -> each flag matches the A-vs-B relation one cycle later and is always one-hot.
REQ-029 Run the full 256-pair sweep with COMPARATOR_STATS_EN defined -> gt_cnt=120, eq_cnt=16, lt_cnt=120.
REQ-030 Hold a=15, b=14 for 70000 cycles with CNT_W=16 -> gt_cnt=65535, held at saturation.
REQ-031 Assert stats_clr while a=b=5 -> eq_cnt=0 on the following cycle, not 1.
REQ-032 Assert rst asynchronously mid-cycle with a=9, b=3 (gt=1) -> gt drops to 0 before the next clock edge.
